// File: rtl/alu_ctrl_muldiv_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_muldiv_if
// Bundles the signals between the ID/EX stage and the EX-stage ALU control /
// multiply-divide sequencer.
//   master : drives the EX instruction fields (pipeline side)
//   slave  : decodes them and returns ALU control, stall and HI/LO results
// Signals:
//   in_valid, flush        EX instruction valid / synchronous kill
//   alu_op[3:0], funct[5:0] opcode class and funct field
//   rs_data, rt_data       operands A/B
//   alu_ctrl, jr           combinational decode results
//   stall                  hold IF/ID/EX while a mul/div runs
//   hilo_rdata             HI or LO for mfhi/mflo, else 0
//   hi, lo                 architectural HI/LO registers
// -----------------------------------------------------------------------------
interface alu_ctrl_muldiv_if #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 6
);
   logic              in_valid;
   logic              flush;
   logic [3:0]        alu_op;
   logic [5:0]        funct;
   logic [XLEN-1:0]   rs_data;
   logic [XLEN-1:0]   rt_data;
   logic [CTRL_W-1:0] alu_ctrl;
   logic              jr;
   logic              stall;
   logic [XLEN-1:0]   hilo_rdata;
   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;

   modport master (
      output in_valid, flush, alu_op, funct, rs_data, rt_data,
      input  alu_ctrl, jr, stall, hilo_rdata, hi, lo
   );

   modport slave (
      input  in_valid, flush, alu_op, funct, rs_data, rt_data,
      output alu_ctrl, jr, stall, hilo_rdata, hi, lo
   );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// -----------------------------------------------------------------------------
// alu_ctrl_muldiv
// EX-stage ALU control decode plus an iterative multiply/divide sequencer with
// architectural HI/LO registers and a pipeline stall output.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_ctrl_muldiv_if.slave (instruction fields in, decode/stall/HI/LO out)
// One shift-add (mul) or restoring-subtract (div) step per BUSY cycle; the
// final step result is sign-corrected and written straight into HI/LO.
// -----------------------------------------------------------------------------
module alu_ctrl_muldiv #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 6,
   parameter int MD_EN  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_ctrl_muldiv_if.slave   bus
);
   localparam int              CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
   localparam bit              MD    = (MD_EN != 0);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   acc_q, acc_d;     // product high half / partial remainder
   logic [XLEN-1:0]   q_q, q_d;         // multiplier / dividend-then-quotient
   logic [XLEN-1:0]   b_q, b_d;         // multiplicand / divisor magnitude
   logic              neg_q, neg_d;     // negate product / quotient
   logic              rneg_q, rneg_d;   // negate remainder (dividend sign)
   logic              div_q, div_d;
   logic              dz_q, dz_d;       // divide by zero
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic              is_rtype, md_funct, md_start, mt_ok;
   logic [CTRL_W-1:0] ctrl;

   assign is_rtype = (bus.alu_op == 4'd1);
   assign md_funct = MD && is_rtype && (bus.funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
   assign md_start = bus.in_valid && !bus.flush && md_funct && (state_q == IDLE);
   // mthi/mtlo may only retire outside a running operation
   assign mt_ok    = MD && bus.in_valid && !bus.flush && is_rtype && (state_q != BUSY);

   always_comb begin
      ctrl = '0;
      if (bus.alu_op == 4'd2) begin
         ctrl = CTRL_W'(1);
      end else if (is_rtype) begin
         case (bus.funct)
            6'h22:   ctrl = CTRL_W'(1);
            6'h24:   ctrl = CTRL_W'(2);
            6'h25:   ctrl = CTRL_W'(3);
            6'h2A:   ctrl = CTRL_W'(4);
            6'h26:   ctrl = CTRL_W'(5);
            6'h27:   ctrl = CTRL_W'(6);
            6'h00:   ctrl = CTRL_W'(7);
            6'h02:   ctrl = CTRL_W'(8);
            6'h03:   ctrl = CTRL_W'(9);
            6'h10:   ctrl = MD ? CTRL_W'(10) : '0;
            6'h12:   ctrl = MD ? CTRL_W'(11) : '0;
            default: ctrl = '0;
         endcase
      end
   end

   assign bus.alu_ctrl   = ctrl;
   assign bus.jr         = is_rtype && (bus.funct == 6'h08);
   assign bus.stall      = md_start || (state_q == BUSY);
   assign bus.hilo_rdata = (MD && is_rtype && bus.funct == 6'h10) ? hi_q :
                           (MD && is_rtype && bus.funct == 6'h12) ? lo_q : '0;
   assign bus.hi         = hi_q;
   assign bus.lo         = lo_q;

   // ---- single iteration step -------------------------------------------
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic              div_ok;
   logic [XLEN-1:0]   acc_step, q_step;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;

   assign mul_sum   = {1'b0, acc_q} + {1'b0, (q_q[0] ? b_q : {XLEN{1'b0}})};
   assign div_shift = {acc_q, q_q[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, b_q};
   // partial remainder is always < 2*divisor, so the top bit is a clean borrow
   assign div_ok    = ~div_diff[XLEN];
   assign acc_step  = div_q ? (div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0])
                            : mul_sum[XLEN:1];
   assign q_step    = div_q ? {q_q[XLEN-2:0], div_ok} : {mul_sum[0], q_q[XLEN-1:1]};

   assign prod      = {acc_step, q_step};
   assign prod_fix  = neg_q ? -prod : prod;
   assign quo_fix   = dz_q ? {XLEN{1'b1}} : (neg_q ? -q_step : q_step);
   assign rem_fix   = rneg_q ? -acc_step : acc_step;

   // ---- next state --------------------------------------------------------
   logic              op_signed, rs_neg, rt_neg;
   logic [XLEN-1:0]   rs_abs, rt_abs;

   assign op_signed = ~bus.funct[0];
   assign rs_neg    = op_signed && bus.rs_data[XLEN-1];
   assign rt_neg    = op_signed && bus.rt_data[XLEN-1];
   assign rs_abs    = rs_neg ? -bus.rs_data : bus.rs_data;
   assign rt_abs    = rt_neg ? -bus.rt_data : bus.rt_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      b_d     = b_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      div_d   = div_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (md_start) begin
               state_d = BUSY;
               cnt_d   = '0;
               acc_d   = '0;
               div_d   = bus.funct[1];
               neg_d   = rs_neg ^ rt_neg;
               rneg_d  = rs_neg;
               dz_d    = (bus.rt_data == '0);
               q_d     = bus.funct[1] ? rs_abs : rt_abs;
               b_d     = bus.funct[1] ? rt_abs : rs_abs;
            end
            if (mt_ok && bus.funct == 6'h11) hi_d = bus.rs_data;
            if (mt_ok && bus.funct == 6'h13) lo_d = bus.rs_data;
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_step;
            q_d   = q_step;
            if (cnt_q == LAST) begin
               state_d = DONE;
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*XLEN-1:XLEN];
                  lo_d = prod_fix[XLEN-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // flush abandons a running operation without touching HI/LO
      if (bus.flush) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         b_q     <= b_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_muldiv
// Directed bench: a decode vector table, a mul/div vector table with
// hand-computed HI/LO results, and hand-written sequences for DONE-cycle
// retirement, flush, mthi/mtlo and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_muldiv;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   alu_ctrl_muldiv_if #(.XLEN(32), .CTRL_W(6)) bus ();

   alu_ctrl_muldiv #(.XLEN(32), .CTRL_W(6), .MD_EN(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [3:0] op;
      logic [5:0] fn;
      logic [5:0] ctrl;
      logic       jr;
   } dec_vec_t;

   typedef struct {
      logic [5:0]  fn;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
   } md_vec_t;

   dec_vec_t dv[18];
   md_vec_t  mv[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic valid, input logic fl);
      @(posedge clk);
      #1;
      bus.alu_op   = op;
      bus.funct    = fn;
      bus.rs_data  = rs;
      bus.rt_data  = rt;
      bus.in_valid = valid;
      bus.flush    = fl;
   endtask

   // Issues a mul/div and holds it in EX until stall drops (the DONE cycle).
   task automatic run_md(input md_vec_t v);
      int n;
      drive(4'd1, v.fn, v.rs, v.rt, 1'b1, 1'b0);
      n = 0;
      @(negedge clk);
      while (bus.stall && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("stall_len", 32'(n), 32'd33);
      chk("md_hi", bus.hi, v.hi);
      chk("md_lo", bus.lo, v.lo);
      $display("md funct=%h rs=%h rt=%h stall_cycles=%0d hi=%h lo=%h", v.fn, v.rs, v.rt, n,
               bus.hi, bus.lo);
   endtask

   initial begin
      dv[0]  = '{4'd0, 6'h08, 6'd0,  1'b0};
      dv[1]  = '{4'd2, 6'h20, 6'd1,  1'b0};
      dv[2]  = '{4'd1, 6'h20, 6'd0,  1'b0};
      dv[3]  = '{4'd1, 6'h22, 6'd1,  1'b0};
      dv[4]  = '{4'd1, 6'h24, 6'd2,  1'b0};
      dv[5]  = '{4'd1, 6'h25, 6'd3,  1'b0};
      dv[6]  = '{4'd1, 6'h2A, 6'd4,  1'b0};
      dv[7]  = '{4'd1, 6'h26, 6'd5,  1'b0};
      dv[8]  = '{4'd1, 6'h27, 6'd6,  1'b0};
      dv[9]  = '{4'd1, 6'h00, 6'd7,  1'b0};
      dv[10] = '{4'd1, 6'h02, 6'd8,  1'b0};
      dv[11] = '{4'd1, 6'h03, 6'd9,  1'b0};
      dv[12] = '{4'd1, 6'h10, 6'd10, 1'b0};
      dv[13] = '{4'd1, 6'h12, 6'd11, 1'b0};
      dv[14] = '{4'd1, 6'h08, 6'd0,  1'b1};
      dv[15] = '{4'd1, 6'h3F, 6'd0,  1'b0};
      dv[16] = '{4'd3, 6'h22, 6'd0,  1'b0};
      dv[17] = '{4'd15, 6'h2A, 6'd0, 1'b0};

      mv[0] = '{6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      mv[1] = '{6'h19, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
      mv[2] = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      mv[3] = '{6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
      mv[4] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      mv[5] = '{6'h1B, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      mv[6] = '{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      mv[7] = '{6'h18, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      mv[8] = '{6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      mv[9] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.alu_op   = 4'd0;
      bus.funct    = 6'h00;
      bus.rs_data  = '0;
      bus.rt_data  = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_hi", bus.hi, 32'h0);
      chk("rst_lo", bus.lo, 32'h0);
      chk("rst_stall", {31'b0, bus.stall}, 32'h0);
      rst_n = 1'b1;

      // decode sweep
      for (int i = 0; i < 18; i++) begin
         drive(dv[i].op, dv[i].fn, 32'h0, 32'h0, 1'b0, 1'b0);
         @(negedge clk);
         chk("dec_ctrl", {26'b0, bus.alu_ctrl}, {26'b0, dv[i].ctrl});
         chk("dec_jr", {31'b0, bus.jr}, {31'b0, dv[i].jr});
         $display("dec op=%0d funct=%h alu_ctrl=%0d jr=%0d", dv[i].op, dv[i].fn, bus.alu_ctrl,
                  bus.jr);
      end

      // mul/div table
      for (int i = 0; i < 10; i++) run_md(mv[i]);

      // mult held through stall, then mflo/mfhi: no restart in DONE
      run_md(mv[0]);
      drive(4'd1, 6'h12, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mflo_norestart", {31'b0, bus.stall}, 32'h0);
      chk("mflo_ctrl", {26'b0, bus.alu_ctrl}, 32'd11);
      chk("mflo_rdata", bus.hilo_rdata, 32'hFFFFFFEB);
      drive(4'd1, 6'h10, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mfhi_rdata", bus.hilo_rdata, 32'hFFFFFFFF);
      $display("seq mflo/mfhi after mult hilo_rdata=%h", bus.hilo_rdata);

      // flush in BUSY cycle 10
      drive(4'd1, 6'h1B, 32'd100, 32'd7, 1'b1, 1'b0);
      repeat (11) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_busy_stall", {31'b0, bus.stall}, 32'h1);
      drive(4'd0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("flush_stall_drop", {31'b0, bus.stall}, 32'h0);
      chk("flush_hi", bus.hi, 32'hFFFFFFFF);
      chk("flush_lo", bus.lo, 32'hFFFFFFEB);
      repeat (40) @(negedge clk);
      chk("flush_hi_later", bus.hi, 32'hFFFFFFFF);
      chk("flush_lo_later", bus.lo, 32'hFFFFFFEB);
      $display("seq flush in busy hi=%h lo=%h", bus.hi, bus.lo);

      // flush together with a would-be start
      drive(4'd1, 6'h18, 32'd5, 32'd5, 1'b1, 1'b1);
      @(negedge clk);
      chk("flush_start_stall", {31'b0, bus.stall}, 32'h0);
      drive(4'd0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("flush_start_idle", {31'b0, bus.stall}, 32'h0);
      repeat (35) @(negedge clk);
      chk("flush_start_lo", bus.lo, 32'hFFFFFFEB);
      $display("seq flush with start lo=%h", bus.lo);

      // mthi / mtlo then mfhi / mflo
      drive(4'd1, 6'h11, 32'h00001234, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mthi_stall", {31'b0, bus.stall}, 32'h0);
      drive(4'd1, 6'h10, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mfhi_rdata2", bus.hilo_rdata, 32'h00001234);
      chk("mfhi_ctrl", {26'b0, bus.alu_ctrl}, 32'd10);
      chk("mfhi_stall", {31'b0, bus.stall}, 32'h0);
      drive(4'd1, 6'h13, 32'h00005678, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mtlo_hilo_zero", bus.hilo_rdata, 32'h0);
      drive(4'd1, 6'h12, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mflo_rdata2", bus.hilo_rdata, 32'h00005678);
      chk("mthi_keeps_hi", bus.hi, 32'h00001234);
      $display("seq mthi/mtlo hi=%h lo=%h", bus.hi, bus.lo);

      // asynchronous reset mid-divide
      drive(4'd1, 6'h1A, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      #1;
      chk("arst_hi", bus.hi, 32'h0);
      chk("arst_lo", bus.lo, 32'h0);
      chk("arst_stall", {31'b0, bus.stall}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("arst_hi_later", bus.hi, 32'h0);
      chk("arst_lo_later", bus.lo, 32'h0);
      $display("seq async reset mid-div hi=%h lo=%h", bus.hi, bus.lo);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
